// File: rtl/pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// pwm_multi_channel
//
// Multi-channel PWM generator. All channels share one prescaler and one
// period counter. Each channel has its own duty value, output enable, PWM
// enable and polarity. The counter runs edge-aligned (0..P, wrap) or
// center-aligned (0..P..1, repeat).
//
// Timing configuration (prescale, period, mode, duty) is double-buffered:
// the shadow copies load only at a period boundary, and only after an update
// request. Because of this, a period is never built from mixed old and new
// settings. out_en, pwm_en and polarity are not shadowed. They take effect on
// the next clock.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   prescale       counter ticks every prescale+1 clocks (shadowed)
//   period         counter top value P (shadowed)
//   mode           0 = edge-aligned, 1 = center-aligned (shadowed)
//   duty_flat      channel i duty at [i*CNT_W +: CNT_W] (shadowed)
//   out_en         static level / enable per channel
//   pwm_en         apply PWM to the channel
//   polarity       1 = invert the final output
//   update_req     single-cycle pulse: load shadows at the next boundary
//   update_pending high from a request until the shadows are loaded
//   period_start   one-clock pulse in the cycle the counter becomes 0
//   out            registered channel outputs
//
// Direction FSM (center mode only; edge mode stays in DIR_UP)
//   state    | meaning
//   DIR_UP   | counter climbing toward period_sh
//   DIR_DOWN | counter descending toward 0
// ---------------------------------------------------------------------------
module pwm_multi_channel #(
  parameter int NUM_CH  = 16,
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [CNT_W-1:0]          period,
  input  logic                      mode,
  input  logic [NUM_CH*CNT_W-1:0]   duty_flat,
  input  logic [NUM_CH-1:0]         out_en,
  input  logic [NUM_CH-1:0]         pwm_en,
  input  logic [NUM_CH-1:0]         polarity,
  input  logic                      update_req,
  output logic                      update_pending,
  output logic                      period_start,
  output logic [NUM_CH-1:0]         out
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

  // shadow registers
  logic [PRESC_W-1:0]      prescale_sh_q;
  logic [CNT_W-1:0]        period_sh_q;
  logic                    mode_sh_q;
  logic [NUM_CH*CNT_W-1:0] duty_sh_q;

  // timebase state
  logic [PRESC_W-1:0]      presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  dir_e                    dir_q, dir_d;

  logic                    update_pending_q, update_pending_d;
  logic                    period_start_q;
  logic [NUM_CH-1:0]       out_q, out_d;

  // counter value / direction the next tick would produce
  logic [CNT_W-1:0]        cnt_step;
  dir_e                    dir_step;

  logic                    tick;
  logic                    boundary;
  logic                    load_sh;

  assign tick = (presc_cnt_q == prescale_sh_q);

  always_comb begin
    presc_cnt_d = presc_cnt_q + PRESC_ONE;
    if (tick) begin
      presc_cnt_d = '0;
    end
  end

  // Next counter value on a tick. The >= comparisons keep the counter
  // inside 0..period_sh even if it were ever out of range.
  always_comb begin
    cnt_step = cnt_q;
    dir_step = dir_q;
    if (!mode_sh_q) begin
      dir_step = DIR_UP;
      if (cnt_q >= period_sh_q) begin
        cnt_step = '0;
      end else begin
        cnt_step = cnt_q + CNT_ONE;
      end
    end else if (period_sh_q == '0) begin
      // Degenerate center mode: hold at 0, so every tick is a boundary.
      cnt_step = '0;
      dir_step = DIR_UP;
    end else if ((dir_q == DIR_UP) && (cnt_q < period_sh_q)) begin
      cnt_step = cnt_q + CNT_ONE;
      dir_step = DIR_UP;
    end else begin
      // Turning at the top, or already descending. Reaching 0 re-arms UP.
      if (cnt_q == '0) begin
        cnt_step = '0;
      end else begin
        cnt_step = cnt_q - CNT_ONE;
      end
      if (cnt_q <= CNT_ONE) begin
        dir_step = DIR_UP;
      end else begin
        dir_step = DIR_DOWN;
      end
    end
  end

  assign boundary = tick && (cnt_step == '0);
  assign load_sh  = boundary && (update_pending_q || update_req);

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (tick) begin
      cnt_d = cnt_step;
      dir_d = dir_step;
    end
    if (load_sh) begin
      dir_d = DIR_UP;
    end
  end

  // A request that coincides with a boundary is consumed there, so
  // update_pending never rises for it.
  always_comb begin
    update_pending_d = update_pending_q;
    if (load_sh) begin
      update_pending_d = 1'b0;
    end else if (update_req) begin
      update_pending_d = 1'b1;
    end
  end

  // The compare uses the pre-edge counter. All-ones duty is treated as 100%
  // even when period_sh is also all-ones.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic act;
      act = (&duty_sh_q[i*CNT_W +: CNT_W]) ||
            (cnt_q < duty_sh_q[i*CNT_W +: CNT_W]);
      out_d[i] = polarity[i] ^ (pwm_en[i] ? (out_en[i] & act) : out_en[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_q      <= '0;
      cnt_q            <= '0;
      dir_q            <= DIR_UP;
      update_pending_q <= 1'b1;
      period_start_q   <= 1'b0;
      out_q            <= '0;
    end else begin
      presc_cnt_q      <= presc_cnt_d;
      cnt_q            <= cnt_d;
      dir_q            <= dir_d;
      update_pending_q <= update_pending_d;
      period_start_q   <= boundary;
      out_q            <= out_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_sh_q <= '0;
      period_sh_q   <= '0;
      mode_sh_q     <= 1'b0;
      duty_sh_q     <= '0;
    end else if (load_sh) begin
      prescale_sh_q <= prescale;
      period_sh_q   <= period;
      mode_sh_q     <= mode;
      duty_sh_q     <= duty_flat;
    end
  end

  assign update_pending = update_pending_q;
  assign period_start   = period_start_q;
  assign out            = out_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi_channel
//
// Directed bench for pwm_multi_channel.
//
// The reference model tracks the phase, in clocks, within the current period.
// From that phase it derives the counter value and the period length
// arithmetically. A single compare process checks out, period_start and
// update_pending against the model on every falling edge.
//
// The main sequence adds hand-computed window counts: high clocks and
// period_start pulses over whole periods, boundary spacing, and pending
// behaviour.
// ---------------------------------------------------------------------------
module tb_pwm_multi_channel;
  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [PRESC_W-1:0]      prescale = '0;
  logic [CNT_W-1:0]        period = '0;
  logic                    mode = 1'b0;
  logic [NUM_CH*CNT_W-1:0] duty_flat = '0;
  logic [NUM_CH-1:0]       out_en = '0;
  logic [NUM_CH-1:0]       pwm_en = '0;
  logic [NUM_CH-1:0]       polarity = '0;
  logic                    update_req = 1'b0;
  logic                    update_pending;
  logic                    period_start;
  logic [NUM_CH-1:0]       out;

  always #5 clk = ~clk;

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst_n(rst_n), .prescale(prescale), .period(period),
    .mode(mode), .duty_flat(duty_flat), .out_en(out_en), .pwm_en(pwm_en),
    .polarity(polarity), .update_req(update_req),
    .update_pending(update_pending), .period_start(period_start), .out(out)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_phase, m_ps, m_P, m_mode, m_c;
  int               m_duty [NUM_CH];
  bit               m_pend, m_pstart, m_act;
  logic [NUM_CH-1:0] m_out;

  function automatic int m_cnt(int phase, int ps, int p, int md);
    int t;
    t = phase / (ps + 1);
    if (md == 0) return t;
    return (t <= p) ? t : 2 * p - t;
  endfunction

  function automatic int m_len(int ps, int p, int md);
    if (md == 0) return (p + 1) * (ps + 1);
    if (p == 0) return ps + 1;
    return 2 * p * (ps + 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_ps = 0; m_P = 0; m_mode = 0;
      for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
      m_pend = 1'b1; m_pstart = 1'b0; m_out = '0;
    end else begin
      m_c = m_cnt(m_phase, m_ps, m_P, m_mode);
      for (int i = 0; i < NUM_CH; i++) begin
        m_act = (m_duty[i] == 255) || (m_c < m_duty[i]);
        m_out[i] = polarity[i] ^ (pwm_en[i] ? (out_en[i] & m_act) : out_en[i]);
      end
      if (m_phase == m_len(m_ps, m_P, m_mode) - 1) begin
        m_pstart = 1'b1;
        m_phase  = 0;
        if (m_pend || update_req) begin
          m_ps = int'(prescale); m_P = int'(period); m_mode = int'(mode);
          for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty_flat[i*CNT_W +: CNT_W]);
          m_pend = 1'b0;
        end
      end else begin
        m_pstart = 1'b0;
        m_phase++;
        if (update_req) m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_out", out, m_out);
      chk("model_period_start", period_start, m_pstart);
      chk("model_update_pending", update_pending, m_pend);
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic req();
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic wait_ps(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < budget);
    chk("wait_period_start", period_start, 1);
  endtask

  task automatic measure(input int n, input int ch, output int hi, output int ps, output int pend);
    hi = 0; ps = 0; pend = 0;
    repeat (n) begin
      @(negedge clk);
      hi   += int'(out[ch]);
      ps   += int'(period_start);
      pend += int'(update_pending);
    end
  endtask

  task automatic set_duty(input int ch, input int d);
    duty_flat[ch*CNT_W +: CNT_W] = CNT_W'(d);
  endtask

  int hi, ps, pend, gap;

  initial begin
    // reset state
    step(2);
    chk("rst_out", out, 0);
    chk("rst_period_start", period_start, 0);
    chk("rst_update_pending", update_pending, 1);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("first_tick_boundary", period_start, 1);
    chk("first_tick_load", update_pending, 0);

    // edge mode, P=9, duty 3
    prescale = 0; period = 9; mode = 0; set_duty(0, 3);
    out_en = 16'h0001; pwm_en = 16'h0001; polarity = 16'h0000;
    req();
    wait_ps(50);
    measure(100, 0, hi, ps, pend);
    chk("edge_d3_high", hi, 30);
    chk("edge_d3_pstart", ps, 10);

    set_duty(0, 0); req(); wait_ps(50);
    measure(100, 0, hi, ps, pend);
    chk("edge_d0_high", hi, 0);

    set_duty(0, 10); req(); wait_ps(50);
    measure(100, 0, hi, ps, pend);
    chk("edge_d10_high", hi, 100);

    // center mode, P=4, duty 2
    mode = 1; period = 4; set_duty(0, 2); req(); wait_ps(50);
    measure(80, 0, hi, ps, pend);
    chk("center_high", hi, 30);
    chk("center_pstart", ps, 10);

    // center mode, P=0: every tick is a boundary
    prescale = 2; period = 0; set_duty(0, 1); req(); wait_ps(50);
    measure(30, 0, hi, ps, pend);
    chk("center_p0_pstart", ps, 10);
    chk("center_p0_high", hi, 30);

    // shadowing
    prescale = 0; period = 9; mode = 0; set_duty(0, 3); req(); wait_ps(50);
    step(3);
    set_duty(0, 7);
    measure(100, 0, hi, ps, pend);
    chk("noreq_unchanged", hi, 30);
    wait_ps(20);
    step(2);
    req();
    chk("pending_set", update_pending, 1);
    wait_ps(20);
    chk("pending_clear_at_boundary", update_pending, 0);
    measure(100, 0, hi, ps, pend);
    chk("duty7_applied", hi, 70);

    // request coincident with a boundary
    wait_ps(20);
    step(9);
    set_duty(0, 5);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    chk("coincident_boundary", period_start, 1);
    chk("coincident_no_pending", update_pending, 0);
    measure(100, 0, hi, ps, pend);
    chk("coincident_pending_count", pend, 0);
    chk("coincident_duty5", hi, 50);

    // prescale 12, P=255, duty 0x80
    prescale = 12; period = 255; set_duty(0, 8'h80); req(); wait_ps(50);
    wait_ps(4000);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!period_start && gap < 4000);
    chk("presc_spacing", gap, 3328);
    measure(3328, 0, hi, ps, pend);
    chk("presc_high", hi, 1664);
    chk("presc_pstart", ps, 1);

    // channel mixing
    prescale = 0; period = 9; set_duty(0, 3); set_duty(1, 4); req(); wait_ps(4000);
    polarity = 16'h0001; pwm_en = 16'h0002; out_en = 16'h0006;
    @(negedge clk);
    chk("mix_out0", out[0], 1);
    chk("mix_out2", out[2], 1);
    chk("mix_others", out[15:3], 0);
    measure(100, 1, hi, ps, pend);
    chk("mix_out1_pwm", hi, 40);
    polarity = 16'h0000;
    @(negedge clk);
    chk("pol_1clk", out[0], 0);
    out_en = 16'h0007;
    @(negedge clk);
    chk("outen_1clk", out[0], 1);

    // reset mid-period
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_pending", update_pending, 1);
    chk("async_rst_pstart", period_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_first_tick", period_start, 1);
    chk("post_rst_loaded", update_pending, 0);
    measure(100, 1, hi, ps, pend);
    chk("post_rst_out1", hi, 40);
    chk("post_rst_pstart", ps, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0t required=<2000000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Parametrised multi-channel PWM generator. It is the next generation of the fixed 16-channel, single-duty PWM block. Each channel has its own duty value, output polarity and enable, driven from one shared prescaler and one shared period counter. Edge-aligned and center-aligned modes are supported, and timing registers are double-buffered so that updates apply glitch-free at period boundaries. It sits behind the SPI register file and drives uo_out/uio_out.

Parameters:
NUM_CH, 16, number of PWM channels
CNT_W, 8, width of the period counter and of each duty value
PRESC_W, 4, width of the prescaler divide value

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
prescale  input  PRESC_W  tick every prescale+1 clocks (shadowed)
period  input  CNT_W  counter top value P (shadowed)
mode  input  1  0 = edge-aligned, 1 = center-aligned (shadowed)
duty_flat  input  NUM_CH*CNT_W  channel i duty at [i*CNT_W +: CNT_W] (shadowed)
out_en  input  NUM_CH  static output level/enable per channel (not shadowed)
pwm_en  input  NUM_CH  apply PWM to channel (not shadowed)
polarity  input  NUM_CH  1 = invert final output (not shadowed)
update_req  input  1  single-cycle pulse: load shadows at next boundary
update_pending  output  1  high from request until the shadows are loaded
period_start  output  1  one-clock pulse in the cycle the counter becomes 0
out  output  NUM_CH  registered channel outputs

Behaviour:
- Reset (asynchronous, active-low):
  - out = 0, period_start = 0, update_pending = 1.
  - Prescaler count = 0, counter = 0, direction = UP.
  - All shadow registers = 0.
- Prescaler: presc_cnt increments each clk. When presc_cnt == prescale_sh, tick = 1 and presc_cnt clears to 0.
- Edge mode (per tick): counter goes 0,1,..,P, then wraps to 0. Period = (P+1)*(prescale+1) clks.
- Center mode (per tick):
  - States UP and DOWN.
  - UP: counter increments; at P, switch to DOWN and decrement next.
  - DOWN: counter decrements; on reaching 0, switch to UP.
  - Sequence is 0..P..1, then repeats from 0. Period = 2P*(prescale+1) clks.
  - P == 0: counter holds at 0 and every tick is a boundary.
- Boundary: a tick whose next counter value is 0.
  - On the same clk edge the counter becomes 0 and period_start is asserted for exactly one clk.
- Shadow load: at a boundary, if update_pending or update_req is set, load prescale_sh, period_sh, mode_sh and duty_sh[] from the inputs, clear update_pending, and force direction to UP.
  - update_req in the same cycle as a boundary is taken at that boundary, and update_pending stays 0.
  - update_req at any other cycle sets update_pending.
  - Further requests while pending are absorbed.
  - Input changes without a request have no effect on shadowed values.
  - After reset, the first boundary (first tick, since period_sh = 0) loads the shadows.
- Compare per channel, using the counter value from before the edge:
  - active_i = (cnt < duty_sh_i).
  - duty 0 gives constant 0.
  - duty > P gives constant 1 in both modes. This includes all-ones, which means 100%, not (2^CNT_W−1)/2^CNT_W.
- Output, registered with 1-clk latency from the counter/inputs:
  - out_i <= polarity_i ^ (pwm_en_i ? (out_en_i & active_i) : out_en_i).
  - out_en, pwm_en and polarity take effect on the next clk with no boundary wait.
- Widths:
  - Counter and duty compare are unsigned CNT_W bits.
  - Prescaler compare is unsigned PRESC_W bits.
  - No overflow is possible because the counter never exceeds period_sh.
- Reset mid-period: all state returns to reset values immediately. The outputs glitch to 0, which is acceptable.

Test Plan:
- Edge mode, prescale=0, P=9, duty0=3, pwm_en0=1, out_en0=1, update_req pulse -> out[0] is high 3 of every 10 clks; period_start every 10 clks; duty0=0 gives constant 0; duty0=10 gives constant 1.
- Center mode, prescale=0, P=4, duty0=2 -> counter sequence 0,1,2,3,4,3,2,1 repeating; out[0] high 3 of 8 clks, symmetric about counter 0; period_start every 8 clks.
- Shadowing: change duty0 from 3 to 7 mid-period with no request -> output unchanged. Then pulse update_req -> update_pending=1 until the next period_start; duty 7 applies from that period on. A request coincident with a boundary -> update_pending never rises.
- Prescale=12, P=255, duty=0x80, edge mode -> period_start spacing 3328 clks; out high 1664 clks per period.
- Channel mixing: polarity=0x0001, pwm_en=0x0002, out_en=0x0006 -> out[0] constant 1; out[1] PWM; out[2] constant 1; others 0. Each change is visible 1 clk after the input changes.
- Assert rst_n low mid-period -> out=0 and update_pending=1 asynchronously. After release, the first tick loads the shadows and operation resumes correctly.
